// File: rtl/adder_arb_pkg.sv
// Shared types and the round-robin pick function for the adder arbiter.
// rr_pick searches at most MAX_REQ requesters; callers pad narrower vectors.
package adder_arb_pkg;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam int DATA_W_DEF = 32;
  localparam int MAX_REQ    = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // First valid index strictly after 'last', wrapping at numReq.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                    input logic [2:0]         last,
                                    input int                 numReq);
    pick_t      pick;
    logic [4:0] pos;
    pick = '0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      pos = {2'b00, last} + 5'(k);
      if (pos >= 5'(numReq)) pos = pos - 5'(numReq);
      if (k <= numReq && !pick.found && valid[pos[2:0]]) begin
        pick.found = 1'b1;
        pick.idx   = pos[2:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/adder_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational pick from the stored last grant,
// pointer advances only when the owning operation completes.
module rr_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic               i_commit,
  input  logic [ID_W-1:0]    i_commitId,
  output logic               o_found,
  output logic [ID_W-1:0]    o_winner
);

  logic [ID_W-1:0]    r_lastGrant;
  logic [MAX_REQ-1:0] w_validPad;
  pick_t              w_pick;

  always_comb begin
    w_validPad                = '0;
    w_validPad[NUM_REQ-1:0]   = i_valid;
    w_pick                    = rr_pick(w_validPad, 3'(r_lastGrant), NUM_REQ);
  end

  assign o_found  = w_pick.found;
  assign o_winner = ID_W'(w_pick.idx);

  // Last grant starts at the top index so requester 0 wins first after reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_lastGrant <= ID_W'(NUM_REQ - 1);
    end else if (i_commit) begin
      r_lastGrant <= i_commitId;
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one adder between NUM_REQ valid/ready requesters, one operation in
// flight, round-robin grant, result returned on the winner's response channel.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADD_LAT = 0,
  parameter int ID_W    = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [DATA_W-1:0]         add_a,
  output logic [DATA_W-1:0]         add_b,
  input  logic [DATA_W-1:0]         add_c,
  output logic [ID_W-1:0]           grant_id,
  output logic                      busy,
  output logic [31:0]               op_count
);

  localparam int CNT_W = (ADD_LAT > 0) ? $clog2(ADD_LAT + 1) : 1;

  state_t            r_state;
  state_t            w_stateNext;
  logic [CNT_W-1:0]  r_waitCnt;
  logic [DATA_W-1:0] r_addA;
  logic [DATA_W-1:0] r_addB;
  logic [DATA_W-1:0] r_rspData;
  logic [ID_W-1:0]   r_grantId;
  logic [31:0]       r_opCount;
  logic              w_found;
  logic [ID_W-1:0]   w_winner;
  logic              w_commit;
  logic              w_rspHandshake;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .clock      (clock),
    .reset      (reset),
    .i_valid    (req_valid),
    .i_commit   (w_commit),
    .i_commitId (r_grantId),
    .o_found    (w_found),
    .o_winner   (w_winner)
  );

  assign w_rspHandshake = rsp_ready[r_grantId];

  always_comb begin
    w_stateNext = r_state;
    req_ready   = '0;
    w_commit    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_found) begin
          w_stateNext = EXEC;
          if (reset) req_ready[w_winner] = 1'b1;
        end
      end
      EXEC: begin
        if (r_waitCnt == '0) w_stateNext = RESP;
      end
      RESP: begin
        if (w_rspHandshake) begin
          w_stateNext = IDLE;
          w_commit    = 1'b1;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_comb begin
    rsp_valid = '0;
    if (r_state == RESP) rsp_valid[r_grantId] = 1'b1;
  end

  // Operands stay frozen through EXEC so a pipelined adder sees stable inputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_waitCnt <= '0;
      r_addA    <= '0;
      r_addB    <= '0;
      r_rspData <= '0;
      r_grantId <= '0;
      r_opCount <= '0;
    end else begin
      r_state <= w_stateNext;
      unique case (r_state)
        IDLE: begin
          if (w_found) begin
            r_addA    <= req_a[int'(w_winner)*DATA_W +: DATA_W];
            r_addB    <= req_b[int'(w_winner)*DATA_W +: DATA_W];
            r_grantId <= w_winner;
            r_waitCnt <= CNT_W'(ADD_LAT);
          end
        end
        EXEC: begin
          if (r_waitCnt == '0) r_rspData <= add_c;
          else                 r_waitCnt <= r_waitCnt - 1'b1;
        end
        RESP: begin
          if (w_rspHandshake) r_opCount <= r_opCount + 32'd1;
        end
        default: ;
      endcase
    end
  end

  assign add_a    = r_addA;
  assign add_b    = r_addB;
  assign rsp_data = r_rspData;
  assign grant_id = r_grantId;
  assign op_count = r_opCount;
  assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: a combinational-adder instance driven
// against a round-robin reference model, plus a 3-cycle-latency instance.
module tb_adder_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;

  logic                      clock;
  logic                      reset;
  logic [NUM_REQ-1:0]        req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a, req_b;
  logic [DATA_W-1:0]         rsp_data, add_a, add_b, add_c;
  logic [1:0]                grant_id;
  logic                      busy;
  logic [31:0]               op_count;

  logic [NUM_REQ-1:0]        req_valid3, req_ready3, rsp_valid3, rsp_ready3;
  logic [NUM_REQ*DATA_W-1:0] req_a3, req_b3;
  logic [DATA_W-1:0]         rsp_data3, add_a3, add_b3, add_c3;
  logic [1:0]                grant_id3;
  logic                      busy3;
  logic [31:0]               op_count3;
  logic [DATA_W-1:0]         pipe3 [3];

  int          testsRun    = 0;
  int          testsFailed = 0;
  int          modelLast;
  int          modelCount;
  logic [31:0] opA [NUM_REQ];
  logic [31:0] opB [NUM_REQ];

  adder_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADD_LAT(0), .ID_W(2)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .add_a(add_a), .add_b(add_b), .add_c(add_c),
    .grant_id(grant_id), .busy(busy), .op_count(op_count)
  );

  adder_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADD_LAT(3), .ID_W(2)) dut3 (
    .clock(clock), .reset(reset), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_a(req_a3), .req_b(req_b3), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
    .rsp_data(rsp_data3), .add_a(add_a3), .add_b(add_b3), .add_c(add_c3),
    .grant_id(grant_id3), .busy(busy3), .op_count(op_count3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Adders: one combinational, one with a three-register pipeline.
  assign add_c  = add_a + add_b;
  assign add_c3 = pipe3[2];
  always @(posedge clock) begin
    pipe3[0] <= add_a3 + add_b3;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference arbitration: first requesting index after the last served one.
  function automatic int modelPick(input logic [NUM_REQ-1:0] mask);
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (modelLast + k) % NUM_REQ;
      if (mask[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic doReset();
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    reset      = 1'b1;
    modelLast  = NUM_REQ - 1;
    modelCount = 0;
  endtask

  // One full operation: offer mask, check grant, latency, result, hold, release.
  task automatic applyStimulus(input logic [NUM_REQ-1:0] mask,
                               input logic [NUM_REQ-1:0] otherMask,
                               input int rspDelay);
    int                 winner;
    int                 edges;
    logic [31:0]        expSum;
    logic [NUM_REQ-1:0] expOneHot;
    winner    = modelPick(mask);
    expSum    = opA[winner] + opB[winner];
    expOneHot = 4'b0001 << winner;
    @(negedge clock);
    req_valid = mask;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[i*DATA_W +: DATA_W] = opA[i];
      req_b[i*DATA_W +: DATA_W] = opB[i];
    end
    rsp_ready = '0;
    #1;
    checkOutput("reqReady", req_ready, expOneHot);
    @(posedge clock);
    #1;
    req_valid = otherMask;
    checkOutput("grantId", grant_id, winner);
    checkOutput("busyExec", busy, 1);
    checkOutput("addA", add_a, opA[winner]);
    checkOutput("addB", add_b, opB[winner]);
    edges = 0;
    while (rsp_valid == '0 && edges < 20) begin
      @(posedge clock);
      #1;
      edges++;
    end
    checkOutput("latency", edges, 1);
    checkOutput("rspValid", rsp_valid, expOneHot);
    checkOutput("rspData", rsp_data, expSum);
    for (int c = 0; c < rspDelay; c++) begin
      @(posedge clock);
      #1;
      checkOutput("holdValid", rsp_valid, expOneHot);
      checkOutput("holdData", rsp_data, expSum);
      checkOutput("holdReady", req_ready, 0);
    end
    rsp_ready[winner] = 1'b1;
    @(posedge clock);
    #1;
    rsp_ready  = '0;
    modelLast  = winner;
    modelCount = modelCount + 1;
    checkOutput("rspDrop", rsp_valid, 0);
    checkOutput("opCount", op_count, modelCount);
    checkOutput("idleAfterRsp", busy, 0);
    req_valid = '0;
  endtask

  // Wrap-around sum through the latency-3 instance.
  task automatic wrapTestLat3();
    int edges;
    @(negedge clock);
    req_valid3          = 4'b0001;
    req_a3[DATA_W-1:0]  = 32'hFFFF_FFFF;
    req_b3[DATA_W-1:0]  = 32'h0000_0001;
    #1;
    checkOutput("lat3Ready", req_ready3, 4'b0001);
    @(posedge clock);
    #1;
    req_valid3 = '0;
    edges = 0;
    while (rsp_valid3 == '0 && edges < 20) begin
      @(posedge clock);
      #1;
      edges++;
    end
    checkOutput("lat3Latency", edges, 4);
    checkOutput("lat3Data", rsp_data3, 0);
    rsp_ready3 = 4'b0001;
    @(posedge clock);
    #1;
    rsp_ready3 = '0;
    checkOutput("lat3Drop", rsp_valid3, 0);
    checkOutput("lat3Count", op_count3, 1);
  endtask

  initial begin
    int d1;
    int d2;
    reset      = 1'b0;
    req_valid  = 4'b1111;
    req_a      = '0;
    req_b      = '0;
    rsp_ready  = '0;
    req_valid3 = '0;
    req_a3     = '0;
    req_b3     = '0;
    rsp_ready3 = '0;
    modelLast  = NUM_REQ - 1;
    modelCount = 0;

    repeat (2) @(posedge clock);
    #1;
    checkOutput("resetReady", req_ready, 0);
    checkOutput("resetBusy", busy, 0);
    checkOutput("resetRspValid", rsp_valid, 0);
    checkOutput("resetOpCount", op_count, 0);
    checkOutput("resetGrant", grant_id, 0);
    checkOutput("resetRspData", rsp_data, 0);
    req_valid = '0;
    reset     = 1'b1;

    opA[0] = 32'd5;
    opB[0] = 32'd7;
    applyStimulus(4'b0001, 4'b0000, 0);

    doReset();
    for (int n = 0; n < 5; n++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        opA[i] = $urandom;
        opB[i] = $urandom;
      end
      applyStimulus(4'b1111, 4'b1111, 0);
    end

    opA[2] = 32'd40;
    opB[2] = 32'd2;
    applyStimulus(4'b0100, 4'b0010, 10);
    opA[1] = $urandom;
    opB[1] = $urandom;
    applyStimulus(4'b0010, 4'b0000, 0);

    opA[0] = 32'hFFFF_FFFF;
    opB[0] = 32'h0000_0001;
    applyStimulus(4'b0001, 4'b0000, 0);
    wrapTestLat3();

    // Reset lands while requester 1 is in EXEC; last grant must fall back too.
    doReset();
    applyStimulus(4'b0001, 4'b0000, 0);
    @(negedge clock);
    req_valid = 4'b0010;
    #1;
    checkOutput("midReady", req_ready, 4'b0010);
    @(posedge clock);
    #1;
    req_valid = '0;
    checkOutput("midBusy", busy, 1);
    reset = 1'b0;
    @(posedge clock);
    #1;
    reset      = 1'b1;
    modelLast  = NUM_REQ - 1;
    modelCount = 0;
    checkOutput("midResetBusy", busy, 0);
    checkOutput("midResetRspValid", rsp_valid, 0);
    checkOutput("midResetOpCount", op_count, 0);
    checkOutput("midResetAddA", add_a, 0);
    repeat (3) @(posedge clock);
    #1;
    checkOutput("midNoResponse", rsp_valid, 0);
    for (int i = 0; i < NUM_REQ; i++) begin
      opA[i] = $urandom;
      opB[i] = $urandom;
    end
    applyStimulus(4'b1001, 4'b0000, 0);

    for (int n = 0; n < 200; n++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        opA[i] = $urandom;
        opB[i] = $urandom;
      end
      applyStimulus(4'($urandom_range(1, 15)), 4'($urandom_range(0, 15)),
                    int'($urandom_range(0, 3)));
    end

    doReset();
    d1 = int'($urandom_range(0, 99));
    d2 = int'($urandom_range(0, 99));
    for (int n = 0; n < 1000; n++) begin
      opA[1] = 32'(d1);
      opB[1] = 32'(d2);
      applyStimulus(4'b0010, 4'b0000, 0);
      d1 = (d1 + 1) % 100;
      d2 = (d2 + 1) % 100;
    end
    checkOutput("sweepCount", op_count, 1000);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
